regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised register file that succeeds the fixed 2-read/1-write 32x32 register file.
- Adds a configurable number of read ports, same-cycle write-to-read bypass, a hardwired-zero register 0, and a per-register busy-bit scoreboard.
- Targets the pipelined core: decode checks operand/destination hazards, writeback clears them, and a branch redirect flushes all pending producers.

Parameters:
- XLEN, 32: data width of each register.
- AW, 5: address width; number of registers NREGS = 2**AW.
- NUM_RD, 2: number of read ports (1..4).
- BYPASS, 1: 1 enables write-to-read forwarding and same-cycle busy clear on reads; 0 disables both.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data, combinational; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  1 = the operand on port i has an outstanding producer.
- iss_en  in  1  issue request; marks iss_addr as pending.
- iss_addr  in  AW  destination of the issuing instruction.
- iss_ready  out  1  issue is accepted this cycle.
- flush  in  1  clears all busy bits.
- busy_vec  out  NREGS  registered busy bits; bit 0 is always 0.
- pend_cnt  out  AW+1  registered count of set busy bits.

Behaviour:
- Reset: all registers, busy_vec and pend_cnt become 0 on the first rising edge with rst=1. A writeback, issue or flush in that cycle is discarded. This applies mid-operation.
- Register 0: always reads 0. Writes to register 0 are ignored. Issue to address 0 never sets a busy bit and always reports iss_ready=1.
- Write: when wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data at the edge and busy[wr_addr] <= 0. A write to a non-busy register is legal and leaves busy unchanged.
- Read (combinational, zero latency): rd_data_i = regs[rd_addr_i].
  - With BYPASS=1, if wr_en=1, wr_addr==rd_addr_i and the address is nonzero, rd_data_i = wr_data.
  - With BYPASS=0, the new value is visible the cycle after the write.
- rd_busy_i:
  - BYPASS=1: busy[rd_addr_i] & ~(wr_en & wr_addr==rd_addr_i).
  - BYPASS=0: busy[rd_addr_i].
- iss_ready:
  - BYPASS=1: 1 when iss_addr==0, or !busy[iss_addr], or (wr_en & wr_addr==iss_addr). The last term resolves WAW in the same cycle.
  - BYPASS=0: 1 when iss_addr==0 or !busy[iss_addr].
- Issue: when iss_en & iss_ready & iss_addr!=0 & !flush, busy[iss_addr] <= 1.
  - If the same edge also writes iss_addr, the set wins: busy ends at 1 (the new producer) and data takes wr_data.
  - iss_en with iss_ready=0 causes no state change; the requester holds.
- Flush: all busy bits <= 0. Flush beats a same-cycle issue, so the issue is dropped. A same-cycle writeback still commits its data.
- Priority per edge: rst > flush > issue set > writeback clear.
- pend_cnt: registered popcount of the next busy_vec, so it always equals popcount(busy_vec). Range 0..NREGS-1.
- No read-port count limit interacts with the scoreboard; all NUM_RD ports are independent and may alias each other or wr_addr.

Test Plan:
- Reset and x0:
  - Stimulus: assert rst one cycle; then write 0xFFFFFFFF to x0; issue to x0.
  - Required: every read returns 0; busy_vec=0; pend_cnt=0; iss_ready=1 for the x0 issue.
- Write/read with bypass (BYPASS=1):
  - Stimulus: wr_en=1, wr_addr=2, wr_data=0xA5A5A5A5, rd_addr port0=2 in the same cycle; next cycle wr_en=0.
  - Required: rd_data port0=0xA5A5A5A5 in both cycles.
  - With BYPASS=0, the first cycle reads 0.
- Scoreboard round trip:
  - Stimulus: issue x3; next cycle read x3.
  - Required: rd_busy=1, pend_cnt=1, a second issue to x3 sees iss_ready=0.
  - Stimulus: then write 0xDEADBEEF to x3.
  - Required: same-cycle rd_busy=0 and rd_data=0xDEADBEEF; the next cycle busy_vec[3]=0 and pend_cnt=0.
- Simultaneous write and issue on the same register:
  - Stimulus: x5 busy; wr x5=0x12345678 and iss x5 in the same cycle.
  - Required: iss_ready=1; afterwards regs[5]=0x12345678, busy_vec[5]=1, pend_cnt unchanged at 1.
- Flush:
  - Stimulus: issue x1, x4 and x7; then flush in the same cycle as an iss_en to x9 and a wr x4=0x55.
  - Required: busy_vec=0, pend_cnt=0, x9 not busy, regs[4]=0x55.
- Multi-port aliasing and mid-operation reset (NUM_RD=3):
  - Stimulus: all three ports read x6 while x6 is written 0x0BADF00D.
  - Required: all three return 0x0BADF00D.
  - Stimulus: rst together with wr x6=1 and iss x8.
  - Required: x6 reads 0 and busy_vec=0 after the edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hardwired-zero x0, optional write-to-read bypass,
// and a per-register busy-bit scoreboard for decode hazard checks.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    output logic                   iss_ready,
    input  logic                   flush,
    output logic [(1<<AW)-1:0]     busy_vec,
    output logic [AW:0]            pend_cnt
);
    localparam int NREGS = 1 << AW;

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_pendCnt;

    logic [NREGS-1:0] w_busyNext;
    logic [AW:0]      w_popCount;
    logic             w_wrLive;
    logic             w_issHitWr;
    logic             w_issFire;

    assign w_wrLive   = wr_en && (wr_addr != '0);
    // A writeback to the issuing destination retires the old producer this cycle (WAW).
    assign w_issHitWr = (BYPASS != 0) && w_wrLive && (wr_addr == iss_addr);
    assign iss_ready  = (iss_addr == '0) || !r_busy[iss_addr] || w_issHitWr;
    assign w_issFire  = iss_en && iss_ready && (iss_addr != '0) && !flush;

    // Later assignments win: flush over issue set over writeback clear.
    always_comb begin
        w_busyNext = r_busy;
        if (w_wrLive) begin
            w_busyNext[wr_addr] = 1'b0;
        end
        if (flush) begin
            w_busyNext = '0;
        end else if (w_issFire) begin
            w_busyNext[iss_addr] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    always_comb begin
        w_popCount = '0;
        for (int k = 0; k < NREGS; k++) begin
            w_popCount = w_popCount + {{AW{1'b0}}, w_busyNext[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_pendCnt <= '0;
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_busy    <= w_busyNext;
            r_pendCnt <= w_popCount;
            if (w_wrLive) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

    // Each read port is independent; ports may alias each other or the write address.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_fwd;

        assign w_addr = rd_addr[g*AW +: AW];
        assign w_fwd  = (BYPASS != 0) && w_wrLive && (wr_addr == w_addr);
        assign rd_data[g*XLEN +: XLEN] = (w_addr == '0) ? '0 :
                                         w_fwd ? wr_data : r_regs[w_addr];
        assign rd_busy[g] = r_busy[w_addr] && !w_fwd;
    end

    assign busy_vec = r_busy;
    assign pend_cnt = r_pendCnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard (NUM_RD=3, BYPASS=1): driver pushes model
// expectations into a queue, a negedge monitor pops and compares against the DUT.
module tb_regfile_scoreboard;
    localparam int XLEN   = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 3;
    localparam int NREGS  = 32;

    logic                   clk;
    logic                   rst;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic                   iss_ready;
    logic                   flush;
    logic [NREGS-1:0]       busy_vec;
    logic [AW:0]            pend_cnt;

    regfile_scoreboard #(.XLEN(XLEN), .AW(AW), .NUM_RD(NUM_RD), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .flush(flush), .busy_vec(busy_vec), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                     chk;
        logic [NUM_RD-1:0][31:0] rdData;
        logic [NUM_RD-1:0]      rdBusy;
        logic                   issReady;
        logic [NREGS-1:0]       busyVec;
        logic [AW:0]            pendCnt;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] modelRegs [NREGS];
    bit          modelBusy [NREGS];
    int          numChecks = 0;
    int          numFails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        numChecks++;
        if (act !== req) begin
            numFails++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expectations come from the architectural rules: reads see the committed value
    // unless written this cycle, and busy tracks issued-but-not-written destinations.
    task automatic applyStimulus(input bit iRst, input bit iWrEn, input logic [4:0] iWrAddr,
                                 input logic [31:0] iWrData, input logic [4:0] iRd0,
                                 input logic [4:0] iRd1, input logic [4:0] iRd2,
                                 input bit iIssEn, input logic [4:0] iIssAddr,
                                 input bit iFlush, input bit iChk);
        exp_t        e;
        logic [4:0]  rdA [NUM_RD];
        bit          ready;
        int          cnt;
        @(posedge clk);
        #1;
        rst      = iRst;
        wr_en    = iWrEn;
        wr_addr  = iWrAddr;
        wr_data  = iWrData;
        rd_addr  = {iRd2, iRd1, iRd0};
        iss_en   = iIssEn;
        iss_addr = iIssAddr;
        flush    = iFlush;
        rdA[0] = iRd0;
        rdA[1] = iRd1;
        rdA[2] = iRd2;
        e.chk = iChk;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rdA[p] == 0) begin
                e.rdData[p] = 32'h0;
                e.rdBusy[p] = 1'b0;
            end else if (iWrEn && iWrAddr == rdA[p]) begin
                e.rdData[p] = iWrData;
                e.rdBusy[p] = 1'b0;
            end else begin
                e.rdData[p] = modelRegs[rdA[p]];
                e.rdBusy[p] = modelBusy[rdA[p]];
            end
        end
        ready = (iIssAddr == 0) || !modelBusy[iIssAddr] || (iWrEn && iWrAddr == iIssAddr);
        e.issReady = ready;
        cnt = 0;
        for (int r = 0; r < NREGS; r++) begin
            e.busyVec[r] = modelBusy[r];
            cnt += int'(modelBusy[r]);
        end
        e.pendCnt = cnt[AW:0];
        expQ.push_back(e);
        if (iRst) begin
            for (int r = 0; r < NREGS; r++) begin
                modelRegs[r] = 32'h0;
                modelBusy[r] = 1'b0;
            end
        end else begin
            if (iWrEn && iWrAddr != 0) begin
                modelRegs[iWrAddr] = iWrData;
                modelBusy[iWrAddr] = 1'b0;
            end
            if (iFlush) begin
                for (int r = 0; r < NREGS; r++) modelBusy[r] = 1'b0;
            end else if (iIssEn && ready && iIssAddr != 0) begin
                modelBusy[iIssAddr] = 1'b1;
            end
        end
    endtask

    // Monitor: combinational outputs settle well before the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (e.chk) begin
                    for (int p = 0; p < NUM_RD; p++) begin
                        checkOutput($sformatf("rd_data%0d", p), rd_data[p*32 +: 32], e.rdData[p]);
                        checkOutput($sformatf("rd_busy%0d", p), {31'h0, rd_busy[p]}, {31'h0, e.rdBusy[p]});
                    end
                    checkOutput("iss_ready", {31'h0, iss_ready}, {31'h0, e.issReady});
                    checkOutput("busy_vec", busy_vec, e.busyVec);
                    checkOutput("pend_cnt", {26'h0, pend_cnt}, {26'h0, e.pendCnt});
                end
            end
        end
    end

    initial begin
        int waitCycles;
        logic [4:0] a0, a1, a2, wa, ia;
        for (int r = 0; r < NREGS; r++) begin
            modelRegs[r] = 32'h0;
            modelBusy[r] = 1'b0;
        end
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;

        // Power-up state is unknown until the first reset edge.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 2, 32'hA5A5A5A5, 2, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 1, 3, 0, 1);
        applyStimulus(0, 1, 3, 32'hDEADBEEF, 3, 3, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1);
        applyStimulus(0, 1, 5, 32'h12345678, 5, 0, 0, 1, 5, 0, 1);
        applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1);
        applyStimulus(0, 1, 4, 32'h00000055, 4, 9, 1, 1, 9, 1, 1);
        applyStimulus(0, 0, 0, 0, 4, 9, 7, 0, 0, 0, 1);
        applyStimulus(0, 1, 6, 32'h0BADF00D, 6, 6, 6, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 1);
        applyStimulus(1, 1, 6, 32'h00000001, 6, 8, 0, 1, 8, 0, 1);
        applyStimulus(0, 0, 0, 0, 6, 8, 6, 0, 0, 0, 1);

        // Random traffic, biased toward low addresses so hazards and aliasing happen often.
        for (int n = 0; n < 600; n++) begin
            a0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a2 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ia = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
                          a0, a1, a2, $urandom_range(0, 2) != 0, ia,
                          $urandom_range(0, 19) == 0, 1);
        end

        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() != 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL drain actual=%0d required=0 pending expectations", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
